mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage load/store engine consuming the EX/MEM pipeline register outputs (`MemWriteM`, `ResultSrcM`, `MemTypeM`, `ALUResultM`, `WriteDataM`). It turns each memory instruction into a request on a multi-cycle data-memory bus with req/ack handshake, and aligns byte lanes. It stalls the pipeline until the access completes and returns load data for MEM/WB.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles in REQ before the access aborts; range 1..255.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `MemWriteM`  in  1  store request.
- `ResultSrcM`  in  1  load request (result taken from memory).
- `MemTypeM`  in  1  0 = word, 1 = byte.
- `ALUResultM`  in  32  effective byte address.
- `WriteDataM`  in  32  store data; byte stores use bits [7:0].
- `bus_req`  out  1  request valid, registered.
- `bus_we`  out  1  1 = write, registered.
- `bus_addr`  out  32  word-aligned address; bits [1:0] = 0.
- `bus_wdata`  out  32  write data, lane-replicated for bytes.
- `bus_be`  out  4  byte enables.
- `bus_ack`  in  1  access complete, sampled on the rising edge.
- `bus_rdata`  in  32  read data, valid when `bus_ack` = 1.
- `StallM`  out  1  freeze all upstream pipeline registers.
- `ReadDataM`  out  32  load result, valid in DONE; held afterwards.
- `AccessErrM`  out  1  one-cycle pulse in DONE on a timeout or misalignment.

## Operation
- Access condition: `MemWriteM | ResultSrcM`. If both are set, the access is a store: `bus_we` = 1 and `ReadDataM` is unchanged.
- FSM states:
  - IDLE: no access → stay in IDLE. Access → REQ, and register the bus outputs on the same edge.
  - REQ: `bus_ack` = 1 → DONE, with `bus_req` cleared on the same edge. Timeout counter reaches `TIMEOUT_CYCLES` → DONE with an error.
  - DONE: always → IDLE.
- `StallM` = (IDLE & access) | REQ. The signal is combinational and is 0 in DONE, so the pipeline advances at the end of DONE. Inputs are held stable by the stall while in REQ.
- Word access: `bus_be` = 4'b1111; `bus_wdata` = `WriteDataM`; `ReadDataM` = `bus_rdata`.
- Byte access, where b = `ALUResultM[1:0]`:
  - `bus_be` = 1 << b.
  - `bus_wdata` = `{4{WriteDataM[7:0]}}`.
  - `ReadDataM` = `bus_rdata[8b+7:8b]` zero-extended to 32 bits.
- `bus_addr` = `{ALUResultM[31:2], 2'b00}`.
- Timeout: the counter is 8 bits, cleared on entry to REQ, and incremented each REQ cycle without an ack. On abort, `ReadDataM` = 0 and `AccessErrM` = 1 in DONE.
- An ack arriving in the same cycle the counter reaches `TIMEOUT_CYCLES` completes the access normally (ack wins).
- `bus_ack` outside REQ is ignored.

## Timing
- Reset values, applied asynchronously:
  - `bus_req`, `bus_we`, `AccessErrM` = 0.
  - `bus_addr`, `bus_wdata`, `ReadDataM` = 0.
  - `bus_be` = 0.
  - State = IDLE, counter = 0.
  - `StallM` = 0 while `rst_n` = 0.
- Access seen in IDLE at cycle N: `StallM` = 1 in cycle N, and `bus_req` = 1 from cycle N+1.
- Ack sampled at the end of cycle N+k (k ≥ 1): DONE in cycle N+k+1 with `ReadDataM` valid and `StallM` = 0. IDLE follows in cycle N+k+2.
- Minimum access is 3 cycles, with 2 stall cycles (ack in the first REQ cycle).
- `rst_n` low mid-REQ drops `bus_req` immediately. The bus is expected to discard the transaction; no error is flagged.
- Back-to-back accesses: the next access is evaluated in the IDLE cycle after DONE. There is no bus request in DONE.

## Configuration
- `MISALIGN_CHECK_EN` defined:
  - A word access with `ALUResultM[1:0]` ≠ 0 issues no bus request.
  - The FSM goes IDLE → DONE directly, with `StallM` = 1 for the IDLE cycle only.
  - In DONE, `AccessErrM` = 1 and `ReadDataM` = 0.
- `MISALIGN_CHECK_EN` undefined: address bits [1:0] are silently dropped for word accesses, and `AccessErrM` is raised only on timeout.

## Test plan
- Word load, address 0x100, ack on the 3rd REQ cycle with `bus_rdata` = 0xDEADBEEF → `bus_be` = 4'hF; `StallM` high 4 cycles; `ReadDataM` = 0xDEADBEEF in DONE.
- Byte store, address 0x203, `WriteDataM` = 0x12345678, immediate ack → `bus_addr` = 0x200, `bus_be` = 4'b1000, `bus_wdata` = 0x78787878, `bus_we` = 1.
- Byte load, address 0x41, `bus_rdata` = 0xAABBCCDD → `ReadDataM` = 0x000000CC.
- Load with `bus_ack` tied low, `TIMEOUT_CYCLES` = 4 → `bus_req` is high 4 cycles then drops; DONE has `AccessErrM` = 1 and `ReadDataM` = 0; IDLE follows.
- `rst_n` asserted during REQ → `bus_req` = 0 immediately and state = IDLE; a new load after reset completes normally.
- With `MISALIGN_CHECK_EN` defined, word load at 0x102 → `bus_req` never asserted; `AccessErrM` pulses for 1 cycle; `StallM` high 1 cycle.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store engine driving a req/ack data bus with byte-lane alignment and pipeline stall
// Optional build macro: MISALIGN_CHECK_EN rejects misaligned word accesses without issuing a bus request.
// Ports: clk, rst_n (async, active-low); MemWriteM/ResultSrcM/MemTypeM/ALUResultM/WriteDataM from EX/MEM;
//        bus_req/bus_we/bus_addr/bus_wdata/bus_be out and bus_ack/bus_rdata in on the data bus;
//        StallM, ReadDataM, AccessErrM back to the pipeline.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemWriteM,
    input  logic        ResultSrcM,
    input  logic        MemTypeM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        AccessErrM
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
    // the REQ cycle in which the counter would reach TIMEOUT_CYCLES without an ack
    localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 1);
    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        w_access;
    logic        w_load;
    logic        w_misalign;
    logic [31:0] w_rbyte;
    assign w_access = MemWriteM | ResultSrcM;
    // a store wins when both request bits are set, so only a pure load updates ReadDataM
    assign w_load   = ResultSrcM & ~MemWriteM;
`ifdef MISALIGN_CHECK_EN
    assign w_misalign = ~MemTypeM & (ALUResultM[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif
    // inputs are frozen by the stall, so the byte offset is still valid when the ack arrives
    assign w_rbyte = {24'h0, bus_rdata[{ALUResultM[1:0], 3'b000} +: 8]};
    assign StallM  = rst_n & ((r_state == S_IDLE & w_access) | (r_state == S_REQ));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'h0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'h0;
            bus_wdata  <= 32'h0;
            bus_be     <= 4'h0;
            ReadDataM  <= 32'h0;
            AccessErrM <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_access && w_misalign) begin
                        r_state    <= S_DONE;
                        ReadDataM  <= 32'h0;
                        AccessErrM <= 1'b1;
                    end else if (w_access) begin
                        r_state   <= S_REQ;
                        r_cnt     <= 8'h0;
                        bus_req   <= 1'b1;
                        bus_we    <= MemWriteM;
                        bus_addr  <= {ALUResultM[31:2], 2'b00};
                        bus_wdata <= MemTypeM ? {4{WriteDataM[7:0]}} : WriteDataM;
                        bus_be    <= MemTypeM ? 4'b0001 << ALUResultM[1:0] : 4'hF;
                    end
                end
                S_REQ: begin
                    if (bus_ack) begin
                        r_state <= S_DONE;
                        bus_req <= 1'b0;
                        if (w_load)
                            ReadDataM <= MemTypeM ? w_rbyte : bus_rdata;
                    end else begin
                        r_cnt <= r_cnt + 8'h1;
                        if (r_cnt == LP_LAST) begin
                            r_state    <= S_DONE;
                            bus_req    <= 1'b0;
                            ReadDataM  <= 32'h0;
                            AccessErrM <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    AccessErrM <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: self-checking bench for mem_access_unit with directed and randomized accesses
module tb_mem_access_unit;
    localparam int TO = 4;
`ifdef MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemWriteM = 1'b0;
    logic        ResultSrcM = 1'b0;
    logic        MemTypeM = 1'b0;
    logic [31:0] ALUResultM = 32'h0;
    logic [31:0] WriteDataM = 32'h0;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        StallM;
    logic [31:0] ReadDataM;
    logic        AccessErrM;
    int checks = 0;
    int errors = 0;
    logic [31:0] m_rd;
    int          o_stall, o_req;
    logic        o_hung, o_we, o_err, o_req0, o_err0, o_done_req;
    logic [31:0] o_addr, o_wdata, o_rd, o_rd0;
    logic [3:0]  o_be;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .MemTypeM(MemTypeM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .StallM(StallM),
        .ReadDataM(ReadDataM), .AccessErrM(AccessErrM)
    );

    // Presents one access in the current (IDLE) cycle, acks on REQ cycle ack_at (0 = never),
    // records what it observes and returns positioned in the IDLE cycle after DONE.
    task automatic run_access(input logic we, input logic ld, input logic typ, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rd, input int ack_at);
        o_stall = 0; o_req = 0; o_hung = 1'b1; o_we = 1'b0; o_addr = '0; o_wdata = '0; o_be = '0;
        o_rd = '0; o_err = 1'b0; o_done_req = 1'b0;
        MemWriteM = we; ResultSrcM = ld; MemTypeM = typ; ALUResultM = addr; WriteDataM = wd;
        for (int c = 0; c < 300; c++) begin
            #1;
            if (c == 0) begin
                o_req0 = bus_req; o_err0 = AccessErrM; o_rd0 = ReadDataM;
            end
            if (bus_req) begin
                o_req++;
                if (o_req == 1) begin
                    o_we = bus_we; o_addr = bus_addr; o_wdata = bus_wdata; o_be = bus_be;
                end
            end
            bus_ack = bus_req ? (o_req == ack_at) : 1'($urandom);
            bus_rdata = (bus_req && o_req == ack_at) ? rd : $urandom;
            if (StallM) o_stall++;
            else if (c > 0) begin
                o_rd = ReadDataM; o_err = AccessErrM; o_done_req = bus_req; o_hung = 1'b0;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus_ack = 1'b0;
    endtask

    task automatic test_reset;
        MemWriteM = 1'b1; ResultSrcM = 1'b1; ALUResultM = 32'hFFFF_FFFF; WriteDataM = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", StallM); end
        checks++; if ({bus_req, bus_we, AccessErrM} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {bus_req, bus_we, AccessErrM}); end
        checks++; if ({bus_addr, bus_wdata, ReadDataM} !== 96'h0) begin errors++; $display("FAIL reset_data got %h %h %h exp 0", bus_addr, bus_wdata, ReadDataM); end
        checks++; if (bus_be !== 4'h0) begin errors++; $display("FAIL reset_be got %h exp 0", bus_be); end
        MemWriteM = 1'b0; ResultSrcM = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_rd = 32'h0;
        @(negedge clk);
    endtask

    task automatic test_word_load;
        run_access(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 3);
        checks++; if (o_hung !== 1'b0) begin errors++; $display("FAIL word_load_done got hung=%b exp 0", o_hung); end
        checks++; if (o_be !== 4'hF) begin errors++; $display("FAIL word_load_be got %h exp f", o_be); end
        checks++; if (o_stall != 4) begin errors++; $display("FAIL word_load_stall got %0d exp 4", o_stall); end
        checks++; if (o_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL word_load_rd got %h exp deadbeef", o_rd); end
        checks++; if (o_addr !== 32'h100 || o_we !== 1'b0) begin errors++; $display("FAIL word_load_bus got %h/%b exp 100/0", o_addr, o_we); end
        m_rd = 32'hDEADBEEF;
    endtask

    task automatic test_byte_store;
        run_access(1'b1, 1'b0, 1'b1, 32'h203, 32'h12345678, 32'h0, 1);
        checks++; if (o_addr !== 32'h200) begin errors++; $display("FAIL byte_store_addr got %h exp 200", o_addr); end
        checks++; if (o_be !== 4'b1000) begin errors++; $display("FAIL byte_store_be got %b exp 1000", o_be); end
        checks++; if (o_wdata !== 32'h78787878) begin errors++; $display("FAIL byte_store_wdata got %h exp 78787878", o_wdata); end
        checks++; if (o_we !== 1'b1) begin errors++; $display("FAIL byte_store_we got %b exp 1", o_we); end
        checks++; if (o_stall != 2) begin errors++; $display("FAIL byte_store_stall got %0d exp 2", o_stall); end
        checks++; if (o_rd !== m_rd) begin errors++; $display("FAIL byte_store_rd_held got %h exp %h", o_rd, m_rd); end
    endtask

    task automatic test_byte_load;
        run_access(1'b0, 1'b1, 1'b1, 32'h41, 32'h0, 32'hAABBCCDD, 1);
        checks++; if (o_rd !== 32'h000000CC) begin errors++; $display("FAIL byte_load_rd got %h exp 000000cc", o_rd); end
        checks++; if (o_be !== 4'b0010) begin errors++; $display("FAIL byte_load_be got %b exp 0010", o_be); end
        m_rd = 32'hCC;
    endtask

    task automatic test_timeout;
        run_access(1'b0, 1'b1, 1'b0, 32'h80, 32'h0, 32'h55555555, 0);
        checks++; if (o_req != TO) begin errors++; $display("FAIL timeout_req_cycles got %0d exp %0d", o_req, TO); end
        checks++; if (o_err !== 1'b1 || o_rd !== 32'h0) begin errors++; $display("FAIL timeout_done got err=%b rd=%h exp 1/0", o_err, o_rd); end
        checks++; if (o_done_req !== 1'b0) begin errors++; $display("FAIL timeout_done_req got %b exp 0", o_done_req); end
        MemWriteM = 1'b0; ResultSrcM = 1'b0;
        #1;
        checks++; if ({StallM, bus_req, AccessErrM} !== 3'b000) begin errors++; $display("FAIL timeout_idle got %b exp 000", {StallM, bus_req, AccessErrM}); end
        m_rd = 32'h0;
        run_access(1'b0, 1'b1, 1'b0, 32'h84, 32'h0, 32'h0BADF00D, TO);
        checks++; if (o_err !== 1'b0 || o_rd !== 32'h0BADF00D) begin errors++; $display("FAIL ack_wins got err=%b rd=%h exp 0/0badf00d", o_err, o_rd); end
        m_rd = 32'h0BADF00D;
    endtask

    task automatic test_misalign;
        logic [31:0] e_rd;
        e_rd = MIS_EN ? 32'h0 : 32'h11223344;
        run_access(1'b0, 1'b1, 1'b0, 32'h102, 32'h0, 32'h11223344, 1);
        checks++; if (o_req != (MIS_EN ? 0 : 1)) begin errors++; $display("FAIL misalign_req got %0d exp %0d", o_req, MIS_EN ? 0 : 1); end
        checks++; if (o_stall != (MIS_EN ? 1 : 2)) begin errors++; $display("FAIL misalign_stall got %0d exp %0d", o_stall, MIS_EN ? 1 : 2); end
        checks++; if (o_err !== MIS_EN || o_rd !== e_rd) begin errors++; $display("FAIL misalign_done got err=%b rd=%h exp %b/%h", o_err, o_rd, MIS_EN, e_rd); end
        m_rd = e_rd;
    endtask

    task automatic test_reset_mid_req;
        MemWriteM = 1'b0; ResultSrcM = 1'b1; MemTypeM = 1'b0; ALUResultM = 32'h300; bus_ack = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL midreq_started got %b exp 1", bus_req); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({bus_req, StallM, AccessErrM} !== 3'b000) begin errors++; $display("FAIL midreq_reset got %b exp 000", {bus_req, StallM, AccessErrM}); end
        @(negedge clk);
        rst_n = 1'b1;
        m_rd = 32'h0;
        run_access(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 32'hCAFEF00D, TO);
        checks++; if (o_err !== 1'b0 || o_rd !== 32'hCAFEF00D) begin errors++; $display("FAIL midreq_after got err=%b rd=%h exp 0/cafef00d", o_err, o_rd); end
        checks++; if (o_req != TO) begin errors++; $display("FAIL midreq_after_req got %0d exp %0d", o_req, TO); end
        m_rd = 32'hCAFEF00D;
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 60; i++) begin
            logic        we, ld, typ, mis, acked, e_err;
            logic [31:0] addr, wd, rd, e_rd;
            logic [1:0]  b;
            int          kind, ack_at, reqs;
            kind = $urandom_range(1, 3);
            we = kind[0]; ld = kind[1]; typ = 1'($urandom);
            addr = $urandom; wd = $urandom; rd = $urandom;
            ack_at = $urandom_range(0, TO + 1);
            b = addr[1:0];
            mis = MIS_EN && !typ && b != 2'b00;
            acked = ack_at >= 1 && ack_at <= TO;
            reqs = mis ? 0 : (acked ? ack_at : TO);
            e_err = mis || !acked;
            e_rd = e_err ? 32'h0 : (we ? m_rd : (typ ? (rd >> (8 * b)) & 32'hFF : rd));
            run_access(we, ld, typ, addr, wd, rd, ack_at);
            checks++; if (o_hung !== 1'b0) begin errors++; $display("FAIL b2b_hung #%0d got %b exp 0", i, o_hung); end
            checks++; if ({o_req0, o_err0} !== 2'b00 || o_rd0 !== m_rd) begin errors++; $display("FAIL b2b_idle #%0d got req=%b err=%b rd=%h exp 0/0/%h", i, o_req0, o_err0, o_rd0, m_rd); end
            checks++; if (o_stall != reqs + 1 || o_req != reqs) begin errors++; $display("FAIL b2b_cycles #%0d got stall=%0d req=%0d exp %0d/%0d", i, o_stall, o_req, reqs + 1, reqs); end
            checks++; if (o_rd !== e_rd || o_err !== e_err || o_done_req !== 1'b0) begin errors++; $display("FAIL b2b_done #%0d got rd=%h err=%b req=%b exp %h/%b/0", i, o_rd, o_err, o_done_req, e_rd, e_err); end
            if (reqs > 0) begin
                checks++; if (o_addr !== (addr & ~32'h3) || o_we !== we) begin errors++; $display("FAIL b2b_addr #%0d got %h/%b exp %h/%b", i, o_addr, o_we, addr & ~32'h3, we); end
                checks++; if (o_be !== (typ ? 4'(1 << b) : 4'hF)) begin errors++; $display("FAIL b2b_be #%0d got %b exp %b", i, o_be, typ ? 4'(1 << b) : 4'hF); end
                if (we) begin
                    checks++; if (o_wdata !== (typ ? 32'(wd[7:0]) * 32'h01010101 : wd)) begin errors++; $display("FAIL b2b_wdata #%0d got %h exp %h", i, o_wdata, typ ? 32'(wd[7:0]) * 32'h01010101 : wd); end
                end
            end
            m_rd = e_rd;
        end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_store();
        test_byte_load();
        test_timeout();
        test_misalign();
        test_reset_mid_req();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
